dht22_sensor_emu: RTL and testbench

Synthesizable DHT22 sensor responder: the sensor end of the single-wire link that top_dht22 masters. Detects the host start pulse, then returns a 40-bit frame (16b RH, 16b T, 8b checksum) with DHT22 timing. Used as an on-FPGA loopback target and hardware bench for the reader, with error injection for recovery testing. The top level owns the open-drain pad: the line is pulled low when dht_drive_low=1 and released (pull-up) otherwise.

---
 rtl/dht22_pkg.sv | 21 ++
 rtl/dht22_line_sync.sv | 24 ++
 rtl/dht22_sensor_emu.sv | 160 ++++++++++++++++
 tb/tb_dht22_sensor_emu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dht22_pkg.sv
// Shared state encoding, frame size and checksum helper for the DHT22 sensor emulator.
package dht22_pkg;

    localparam int unsigned FRAME_BITS = 40;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StHostLow   = 3'd1;
    localparam logic [2:0] StRespDelay = 3'd2;
    localparam logic [2:0] StRespLow   = 3'd3;
    localparam logic [2:0] StRespHigh  = 3'd4;
    localparam logic [2:0] StBitLow    = 3'd5;
    localparam logic [2:0] StBitHigh   = 3'd6;
    localparam logic [2:0] StEndLow    = 3'd7;

    function automatic logic [7:0] dht22_checksum(input logic [15:0] h, input logic [15:0] t);
        logic [7:0] s;
        s = h[15:8] + h[7:0] + t[15:8] + t[7:0];
        return s;
    endfunction

endpackage

// File: rtl/dht22_line_sync.sv
// Two-flop synchronizer for the single-wire line with registered-level edge pulses.
module dht22_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic rise,
    output logic fall
);

    // [0],[1] synchronize; [2] holds the previous synced level. Reset to the idle-high level.
    logic [2:0] sh_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= 3'b111;
        end else begin
            sh_q <= {sh_q[1:0], line};
        end
    end

    assign rise = sh_q[1] & ~sh_q[2];
    assign fall = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/dht22_sensor_emu.sv
// DHT22 sensor-side responder: detects the host start pulse and returns a 40-bit frame.
module dht22_sensor_emu
    import dht22_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = 100000000,
    parameter int unsigned START_LOW_MIN_US = 800,
    parameter int unsigned RESP_DELAY_US    = 30,
    parameter int unsigned RESP_LOW_US      = 80,
    parameter int unsigned RESP_HIGH_US     = 80,
    parameter int unsigned BIT_LOW_US       = 50,
    parameter int unsigned BIT0_HIGH_US     = 26,
    parameter int unsigned BIT1_HIGH_US     = 70
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dht_in,
    output logic        dht_drive_low,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    input  logic        data_load,
    input  logic        corrupt_parity,
    input  logic [5:0]  truncate_bits,
    output logic        busy,
    output logic        frame_done
);

    localparam int unsigned CYC_PER_US   = CLK_FREQ / 1000000;
    localparam logic [31:0] CycStartMin  = 32'(START_LOW_MIN_US * CYC_PER_US);
    localparam logic [31:0] CycRespDelay = 32'(RESP_DELAY_US * CYC_PER_US);
    localparam logic [31:0] CycRespLow   = 32'(RESP_LOW_US * CYC_PER_US);
    localparam logic [31:0] CycRespHigh  = 32'(RESP_HIGH_US * CYC_PER_US);
    localparam logic [31:0] CycBitLow    = 32'(BIT_LOW_US * CYC_PER_US);
    localparam logic [31:0] CycBit0High  = 32'(BIT0_HIGH_US * CYC_PER_US);
    localparam logic [31:0] CycBit1High  = 32'(BIT1_HIGH_US * CYC_PER_US);

    function automatic logic [31:0] phase_cycles(input logic [2:0] st, input logic one);
        case (st)
            StRespDelay: return CycRespDelay;
            StRespLow:   return CycRespLow;
            StRespHigh:  return CycRespHigh;
            StBitLow:    return CycBitLow;
            StBitHigh:   return one ? CycBit1High : CycBit0High;
            StEndLow:    return CycBitLow;
            default:     return 32'd0;
        endcase
    endfunction

    logic        line_rise, line_fall;
    logic [2:0]  state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] host_cnt_q, host_cnt_d;
    logic [39:0] shift_q, shift_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [5:0]  bit_lim_q, bit_lim_d;
    logic [15:0] stage_h_q, stage_t_q;
    logic        drive_q, busy_q, done_q, done_d;
    logic [31:0] len;

    dht22_line_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .line (dht_in),
        .rise (line_rise),
        .fall (line_fall)
    );

    always_comb begin
        state_d    = state_q;
        host_cnt_d = host_cnt_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        bit_lim_d  = bit_lim_q;
        done_d     = 1'b0;
        case (state_q)
            StIdle: begin
                if (line_fall) begin
                    state_d    = StHostLow;
                    host_cnt_d = 32'd1;
                end
            end
            StHostLow: begin
                if (host_cnt_q != 32'hFFFF_FFFF) host_cnt_d = host_cnt_q + 32'd1;
                if (line_rise) state_d = (host_cnt_q >= CycStartMin) ? StRespDelay : StIdle;
            end
            StRespDelay: begin
                if (line_fall) begin
                    state_d    = StHostLow;
                    host_cnt_d = 32'd1;
                end else if (timer_q == 32'd0) begin
                    shift_d   = {stage_h_q, stage_t_q,
                                 dht22_checksum(stage_h_q, stage_t_q) ^ {8{corrupt_parity}}};
                    bit_cnt_d = 6'd0;
                    bit_lim_d = (truncate_bits == 6'd0 || truncate_bits >= 6'(FRAME_BITS))
                              ? 6'(FRAME_BITS) : truncate_bits;
                    state_d   = StRespLow;
                end
            end
            StRespLow:  if (timer_q == 32'd0) state_d = StRespHigh;
            StRespHigh: if (timer_q == 32'd0) state_d = StBitLow;
            StBitLow:   if (timer_q == 32'd0) state_d = StBitHigh;
            StBitHigh: begin
                if (timer_q == 32'd0) begin
                    shift_d   = {shift_q[38:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q + 6'd1 == bit_lim_q) ? StEndLow : StBitLow;
                end
            end
            StEndLow: begin
                if (timer_q == 32'd0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Reload on every state change so a phase of N cycles spans exactly N clocks.
        len = phase_cycles(state_d, shift_d[39]);
        if (state_d != state_q) begin
            timer_d = (len == 32'd0) ? 32'd0 : len - 32'd1;
        end else begin
            timer_d = (timer_q == 32'd0) ? 32'd0 : timer_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= 32'd0;
            host_cnt_q <= 32'd0;
            shift_q    <= 40'd0;
            bit_cnt_q  <= 6'd0;
            bit_lim_q  <= 6'd0;
            stage_h_q  <= 16'd0;
            stage_t_q  <= 16'd0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            host_cnt_q <= host_cnt_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_lim_q  <= bit_lim_d;
            if (data_load) begin
                stage_h_q <= humidity;
                stage_t_q <= temperature;
            end
            drive_q <= (state_d == StRespLow) || (state_d == StBitLow) || (state_d == StEndLow);
            busy_q  <= (state_d != StIdle) && (state_d != StHostLow);
            done_q  <= done_d;
        end
    end

    assign dht_drive_low = drive_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;

endmodule

// File: tb/tb_dht22_sensor_emu.sv
// Directed bench for dht22_sensor_emu: host start pulses, frame decode, scoreboard of frames.
module tb_dht22_sensor_emu;

    localparam int unsigned CLK_FREQ = 2000000;
    localparam int CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_low;
    logic        dht_in;
    logic        dht_drive_low;
    logic [15:0] humidity, temperature;
    logic        data_load, corrupt_parity;
    logic [5:0]  truncate_bits;
    logic        busy, frame_done;

    typedef struct {
        logic [39:0] frame;
        int          nbits;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] mdl_h = 16'd0;
    logic [15:0] mdl_t = 16'd0;

    always #5 clk = ~clk;

    // Open-drain wire with pull-up: low if either end pulls it.
    assign dht_in = ~(host_low | dht_drive_low);

    dht22_sensor_emu #(
        .CLK_FREQ (CLK_FREQ)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dht_in         (dht_in),
        .dht_drive_low  (dht_drive_low),
        .humidity       (humidity),
        .temperature    (temperature),
        .data_load      (data_load),
        .corrupt_parity (corrupt_parity),
        .truncate_bits  (truncate_bits),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    initial begin
        #1500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_sum(input logic [15:0] h, input logic [15:0] t);
        int s;
        s = int'(h[15:8]) + int'(h[7:0]) + int'(t[15:8]) + int'(t[7:0]);
        return 8'(s % 256);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] h, input logic [15:0] t);
        @(negedge clk);
        humidity = h;
        temperature = t;
        data_load = 1'b1;
        @(negedge clk);
        data_load = 1'b0;
        mdl_h = h;
        mdl_t = t;
    endtask

    task automatic start_frame(input int low_us, input logic corrupt, input logic [5:0] trunc,
                               input bit expect_frame);
        exp_t e;
        corrupt_parity = corrupt;
        truncate_bits = trunc;
        if (expect_frame) begin
            e.frame = {mdl_h, mdl_t, ref_sum(mdl_h, mdl_t) ^ (corrupt ? 8'hFF : 8'h00)};
            e.nbits = (trunc == 6'd0 || trunc >= 6'd40) ? 40 : int'(trunc);
            sb.push_back(e);
        end
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_us * CYC) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Counts consecutive negedge samples where dht_drive_low equals level.
    task automatic run_len(input logic level, input int cap, output int n, output logic fd);
        n = 0;
        fd = frame_done;
        while (dht_drive_low === level && n < cap) begin
            n++;
            @(negedge clk);
            data_load = 1'b0;
        end
    endtask

    task automatic wait_drive(output int w);
        w = 0;
        while (dht_drive_low !== 1'b1 && w < 2000) begin
            w++;
            @(negedge clk);
        end
        check("resp_start", 64'(w < 2000), 64'd1);
    endtask

    task automatic read_frame(input int load_bit, input logic [15:0] lh, input logic [15:0] lt);
        int          n, w, cnt;
        logic        fd, ended;
        logic [39:0] got;
        exp_t        e;
        wait_drive(w);
        check("busy_frame", 64'(busy), 64'd1);
        run_len(1'b1, 1000, n, fd);
        check("resp_low_len", 64'(n), 64'(80 * CYC));
        run_len(1'b0, 1000, n, fd);
        check("resp_high_len", 64'(n), 64'(80 * CYC));
        got = 40'd0;
        cnt = 0;
        ended = 1'b0;
        while (!ended && cnt < 41 && w < 2000) begin
            if (cnt == load_bit) begin
                humidity = lh;
                temperature = lt;
                data_load = 1'b1;
                mdl_h = lh;
                mdl_t = lt;
            end
            run_len(1'b1, 1000, n, fd);
            check("bit_low_len", 64'(n), 64'(50 * CYC));
            run_len(1'b0, 200 * CYC, n, fd);
            if (n == 200 * CYC) begin
                ended = 1'b1;
                check("frame_done", 64'(fd), 64'd1);
            end else begin
                got = {got[38:0], 1'(n == 70 * CYC)};
                check("bit_high_len", 64'(n == 26 * CYC || n == 70 * CYC), 64'd1);
                check("frame_done_quiet", 64'(fd), 64'd0);
                cnt++;
            end
        end
        check("frame_end", 64'(ended), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check("nbits", 64'(cnt), 64'(e.nbits));
            check("frame_data", 64'(got), 64'(e.frame >> (40 - e.nbits)));
        end
    endtask

    initial begin
        int   n, w;
        logic fd, seen;
        rst = 1'b1;
        host_low = 1'b0;
        humidity = 16'd0;
        temperature = 16'd0;
        data_load = 1'b0;
        corrupt_parity = 1'b0;
        truncate_bits = 6'd0;
        repeat (3) @(negedge clk);
        check("rst_drive", 64'(dht_drive_low), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        rst = 1'b0;

        // Nominal frame: 0x028C / 0x80E5, checksum 0xF3.
        load(16'h028C, 16'h80E5);
        start_frame(1000, 1'b0, 6'd0, 1'b1);
        read_frame(-1, 16'h0, 16'h0);

        // Too-short host pulse is ignored.
        start_frame(500, 1'b0, 6'd0, 1'b0);
        seen = 1'b0;
        repeat (300 * CYC) begin
            @(negedge clk);
            seen = seen | dht_drive_low | busy;
        end
        check("glitch_ignored", 64'(seen), 64'd0);

        // Truncated frame, then recovery with a full frame.
        start_frame(1000, 1'b0, 6'd16, 1'b1);
        read_frame(-1, 16'h0, 16'h0);
        start_frame(1000, 1'b0, 6'd0, 1'b1);
        read_frame(-1, 16'h0, 16'h0);

        // Corrupted checksum: 0xF3 ^ 0xFF = 0x0C.
        start_frame(1000, 1'b1, 6'd0, 1'b1);
        read_frame(-1, 16'h0, 16'h0);
        corrupt_parity = 1'b0;

        // New data loaded during bit 10 applies only to the next frame.
        start_frame(1000, 1'b0, 6'd0, 1'b1);
        read_frame(10, 16'h0000, 16'h0001);
        start_frame(1000, 1'b0, 6'd0, 1'b1);
        read_frame(-1, 16'h0, 16'h0);

        // Reset while in the first bit's high phase.
        start_frame(1000, 1'b0, 6'd0, 1'b0);
        wait_drive(w);
        run_len(1'b1, 1000, n, fd);
        run_len(1'b0, 1000, n, fd);
        run_len(1'b1, 1000, n, fd);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_drive", 64'(dht_drive_low), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(frame_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        mdl_h = 16'd0;
        mdl_t = 16'd0;
        start_frame(1000, 1'b0, 6'd0, 1'b1);
        read_frame(-1, 16'h0, 16'h0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
